// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM state type and op decode helpers for mult_div_unit.
package mdu_pkg;
   localparam logic [1:0] MDU_MULT  = 2'b00;
   localparam logic [1:0] MDU_MULTU = 2'b01;
   localparam logic [1:0] MDU_DIV   = 2'b10;
   localparam logic [1:0] MDU_DIVU  = 2'b11;
   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
   function automatic logic is_div(input logic [1:0] op);
      return op == MDU_DIV || op == MDU_DIVU;
   endfunction
   function automatic logic is_signed(input logic [1:0] op);
      return op == MDU_MULT || op == MDU_DIV;
   endfunction
endpackage

// File: rtl/mdu_cond_neg.sv
// mdu_cond_neg: two's-complement negate of d when neg is set, pass-through otherwise.
module mdu_cond_neg #(
   parameter int WIDTH = 32
) (
   input  logic             neg,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   assign q = neg ? -d : d;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed/unsigned MULT/DIV into HI/LO with a start/busy/done handshake.
// Define MDU_EARLY_TERM_EN to end multiply CALC once the remaining multiplier bits are all zero.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);
   state_t state;
   logic [1:0] op_r;
   logic [CW-1:0] cnt;
   logic [2*WIDTH-1:0] acc, mcand, res;
   logic [WIDTH-1:0] mplier, a_mag, b_mag, quo;
   logic [WIDTH:0] rem_sh, diff;
   logic neg_q, neg_r, last;
   mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_a (.neg(is_signed(op) && a[WIDTH-1]), .d(a), .q(a_mag));
   mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_b (.neg(is_signed(op) && b[WIDTH-1]), .d(b), .q(b_mag));
   mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_quo (.neg(neg_q), .d(mplier), .q(quo));
   // The product negator also fixes the remainder sign; zero-extending it keeps the low half exact.
   mdu_cond_neg #(.WIDTH(2*WIDTH)) u_neg_res (
      .neg(is_div(op_r) ? neg_r : neg_q),
      .d(is_div(op_r) ? {{WIDTH{1'b0}}, acc[WIDTH-1:0]} : acc),
      .q(res)
   );
   assign rem_sh = {acc[WIDTH-1:0], mplier[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, mcand[WIDTH-1:0]};
`ifdef MDU_EARLY_TERM_EN
   assign last = cnt == '0 || (!is_div(op_r) && mplier[WIDTH-1:1] == '0);
`else
   assign last = cnt == '0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         div0  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         done <= 1'b0;
         div0 <= 1'b0;
         case (state)
            IDLE: if (start) begin
               op_r   <= op;
               acc    <= '0;
               cnt    <= CW'(WIDTH - 1);
               mcand  <= {{WIDTH{1'b0}}, is_div(op) ? b_mag : a_mag};
               mplier <= is_div(op) ? a_mag : b_mag;
               neg_q  <= is_signed(op) && (a[WIDTH-1] ^ b[WIDTH-1]);
               neg_r  <= is_signed(op) && a[WIDTH-1];
               busy   <= 1'b1;
               if (is_div(op) && b == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
                  div0  <= 1'b1;
               end else
                  state <= CALC;
            end
            CALC: begin
               if (is_div(op_r)) begin
                  acc    <= {{WIDTH{1'b0}}, diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]};
                  mplier <= {mplier[WIDTH-2:0], !diff[WIDTH]};
               end else begin
                  acc    <= mplier[0] ? acc + mcand : acc;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
               end
               cnt   <= cnt - 1'b1;
               state <= last ? FIXUP : CALC;
            end
            FIXUP: begin
               hi    <= is_div(op_r) ? res[WIDTH-1:0] : res[2*WIDTH-1:WIDTH];
               lo    <= is_div(op_r) ? quo : res[WIDTH-1:0];
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
